// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the IF stage: next-PC arbitration, redirect flush and fetch qualification.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic [31:0] pc_next,
    output logic        if_flush,
    output logic        fetch_valid,
    output logic        misalign_err,
    output logic [1:0]  state_out,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redir_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_inc_s;
    logic [2:0]  flush_cnt_r;
    logic        redirect_s;
    logic        misalign_set_s;
    logic        misalign_clr_s;

    assign pc_inc_s  = pc_r + 32'd4;
    assign state_out = state_r;

    // State, PC, flush counter and sticky misalignment flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            flush_cnt_r  <= 3'd0;
            misalign_err <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_next;
            if (redirect_s) begin
                flush_cnt_r <= FLUSH_LOAD;
            end else if (flush_cnt_r != 3'd0) begin
                flush_cnt_r <= flush_cnt_r - 3'd1;
            end else begin
                flush_cnt_r <= 3'd0;
            end
            if (misalign_set_s) begin
                misalign_err <= 1'b1;
            end else if (misalign_clr_s) begin
                misalign_err <= 1'b0;
            end else begin
                misalign_err <= misalign_err;
            end
        end
    end

    // Next-state arbitration; an aligned redirect outranks halt and stall.
    always_comb begin
        state_nxt_s    = state_r;
        redirect_s     = 1'b0;
        misalign_set_s = 1'b0;
        misalign_clr_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (br_taken_i && (br_target_i[1:0] == 2'b00)) begin
                    redirect_s  = 1'b1;
                    state_nxt_s = ST_RUN;
                end else if (br_taken_i) begin
                    misalign_set_s = 1'b1;
                    state_nxt_s    = ST_HALT;
                end else if (halt_i) begin
                    state_nxt_s = ST_HALT;
                end else if (stall_i) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_nxt_s    = ST_RUN;
                    misalign_clr_s = 1'b1;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Next-PC selection and fetch qualifiers.
    always_comb begin
        pc_next     = pc_r;
        if_flush    = (state_r == ST_BOOT) || (flush_cnt_r != 3'd0);
        fetch_valid = (state_r == ST_RUN) && !stall_i && (flush_cnt_r == 3'd0);
        case (state_r)
            ST_BOOT: begin
                pc_next = RESET_PC;
            end
            ST_RUN, ST_STALL: begin
                if (redirect_s) begin
                    pc_next = br_target_i;
                end else if (br_taken_i || halt_i || stall_i) begin
                    pc_next = pc_r;
                end else begin
                    pc_next = pc_inc_s;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    pc_next = pc_inc_s;
                end else begin
                    pc_next = pc_r;
                end
            end
            default: begin
                pc_next = RESET_PC;
            end
        endcase
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] redir_cnt_r;

    // Saturating stall-cycle and accepted-redirect counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
            redir_cnt_r <= 32'd0;
        end else begin
            if ((state_r == ST_STALL) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s && (redir_cnt_r != 32'hFFFF_FFFF)) begin
                redir_cnt_r <= redir_cnt_r + 32'd1;
            end else begin
                redir_cnt_r <= redir_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_redir_cnt = redir_cnt_r;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_redir_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed test-plan steps followed by random traffic,
// all checked against a behavioural model of the next-PC rules.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          NFLUSH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_taken, halt, resume;
    logic [31:0] br_target;
    logic [31:0] pc_next, perf_stall_cnt, perf_redir_cnt;
    logic        if_flush, fetch_valid, misalign_err;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(RST_PC), .FLUSH_CYCLES(NFLUSH)) dut (
        .clk(clk), .reset(reset), .stall_i(stall), .br_taken_i(br_taken),
        .br_target_i(br_target), .halt_i(halt), .resume_i(resume),
        .pc_next(pc_next), .if_flush(if_flush), .fetch_valid(fetch_valid),
        .misalign_err(misalign_err), .state_out(state_out),
        .perf_stall_cnt(perf_stall_cnt), .perf_redir_cnt(perf_redir_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 boot, 1 run, 2 stall, 3 halt.
    int          m_mode;
    logic [31:0] m_pc;
    int          m_flush;
    bit          m_err;
    int unsigned m_stalls, m_redirs;
    // Values derived for the cycle being evaluated.
    logic [31:0] e_pc;
    int          e_mode_next;
    bit          e_err_next, e_accept;
    bit          pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = RST_PC; m_flush = 0; m_err = 1'b0;
        m_stalls = 0; m_redirs = 0;
    endtask

    task automatic model_eval();
        e_accept = 1'b0; e_err_next = m_err; e_mode_next = m_mode; e_pc = m_pc;
        if (m_mode == 0) begin
            e_pc = RST_PC; e_mode_next = 1;
        end else if (m_mode == 3) begin
            if (resume) begin e_pc = m_pc + 32'd4; e_mode_next = 1; e_err_next = 1'b0; end
        end else if (br_taken && (br_target % 4 == 0)) begin
            e_pc = br_target; e_mode_next = 1; e_accept = 1'b1;
        end else if (br_taken) begin
            e_mode_next = 3; e_err_next = 1'b1;
        end else if (halt) begin
            e_mode_next = 3;
        end else if (stall) begin
            e_mode_next = 2;
        end else begin
            e_pc = m_pc + 32'd4; e_mode_next = 1;
        end
    endtask

    task automatic model_check();
        logic [31:0] exp_sc, exp_rc;
`ifdef FETCH_CTRL_PERF_EN
        exp_sc = m_stalls; exp_rc = m_redirs;
`else
        exp_sc = 32'h0; exp_rc = 32'h0;
`endif
        model_eval();
        chk("pc_next", pc_next, e_pc);
        chk("if_flush", {31'd0, if_flush}, {31'd0, (m_mode == 0) || (m_flush != 0)});
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, (m_mode == 1) && !stall && (m_flush == 0)});
        chk("state_out", {30'd0, state_out}, 32'(m_mode));
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        chk("perf_stall_cnt", perf_stall_cnt, exp_sc);
        chk("perf_redir_cnt", perf_redir_cnt, exp_rc);
    endtask

    task automatic model_commit();
        if (m_mode == 2 && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        if (e_accept && m_redirs != 32'hFFFF_FFFF) m_redirs++;
        m_flush = e_accept ? NFLUSH : (m_flush > 0 ? m_flush - 1 : 0);
        m_pc = e_pc; m_mode = e_mode_next; m_err = e_err_next;
    endtask

    task automatic adv();
        if (pending) begin
            @(posedge clk);
            model_commit();
            #1;
            pending = 1'b0;
        end
    endtask

    // One cycle: advance past the edge, apply inputs, check outputs mid-cycle.
    task automatic cyc(input logic b, input logic [31:0] t, input logic s, input logic h, input logic r);
        adv();
        br_taken = b; br_target = t; stall = s; halt = h; resume = r;
        #3;
        model_check();
        pending = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; halt = 1'b0; resume = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_next", pc_next, RST_PC);
        chk("rst_if_flush", {31'd0, if_flush}, 32'd1);
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_state", {30'd0, state_out}, 32'd0);
        reset = 1'b1;

        // Boot then sequential fetch.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("boot_pc", pc_next, 32'h0);
        chk("boot_flush", {31'd0, if_flush}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("run_pc4", pc_next, 32'h4);
        chk("run_valid", {31'd0, fetch_valid}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("run_pc8", pc_next, 32'h8);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("run_pcC", pc_next, 32'hC);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Redirect to 0x40 with a two-cycle flush.
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        chk("redir_pc", pc_next, 32'h40);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("redir_pc44", pc_next, 32'h44);
        chk("flush1", {31'd0, if_flush}, 32'd1);
        chk("flush1_valid", {31'd0, fetch_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush2", {31'd0, if_flush}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_done", {31'd0, if_flush}, 32'd0);

        // Stall at 0x20 with a redirect on the second stall cycle.
        cyc(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stall_hold", pc_next, 32'h20);
        cyc(1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        chk("stall_state", {30'd0, state_out}, 32'd2);
        chk("stall_redir", pc_next, 32'h80);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("stall_run", {30'd0, state_out}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Halt at 0x30, ignored noise, resume.
        cyc(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("halt_pc", pc_next, 32'h30);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
            chk("halt_hold", pc_next, 32'h30);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("resume_pc", pc_next, 32'h34);

        // Misaligned redirect.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_halt", {30'd0, state_out}, 32'd3);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mis_clear", {31'd0, misalign_err}, 32'd0);

        // PC wrap, then asynchronous reset in the middle of the flush.
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", pc_next, 32'h0);
        adv();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_pc", pc_next, RST_PC);
        chk("mid_rst_flush", {31'd0, if_flush}, 32'd1);
        chk("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("mid_rst_state", {30'd0, state_out}, 32'd0);
        chk("mid_rst_redir", perf_redir_cnt, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            cyc(($urandom_range(0, 7) == 0), tgt, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
        end
        adv();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter sequencer for the IF stage: produces the PCNext value that IF registers each cycle.
- Arbitrates the next-PC sources: sequential, branch/jump redirect from EX, hazard stall, halt/resume.
- Generates the IF/ID flush bubble after a redirect and a fetch-valid qualifier.
- Sits between the hazard/EX logic and the IF stage; owns the architectural fetch PC.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FLUSH_CYCLES, 2, number of cycles if_flush stays high after an accepted redirect (1..7)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
stall_i  input  1  hazard unit stall request; hold the PC
br_taken_i  input  1  EX redirect request (taken branch/jump)
br_target_i  input  32  redirect target address
halt_i  input  1  ebreak/ecall decoded; stop fetching
resume_i  input  1  leave HALT
pc_next  output  32  next PC, drives IF PCNext
if_flush  output  1  insert bubble into IF/ID
fetch_valid  output  1  instruction issued this cycle is on the correct path
misalign_err  output  1  sticky: redirect target had bits[1:0]!=0
state_out  output  2  0=BOOT, 1=RUN, 2=STALL, 3=HALT
perf_stall_cnt  output  32  stall-cycle counter (see Optional Feature)
perf_redir_cnt  output  32  accepted-redirect counter (see Optional Feature)

Behaviour:
- Internal pc_q holds the last issued PC. pc_next is combinational from pc_q, the state and the inputs. pc_q <= pc_next on every rising clk.
- Reset (reset=0, asynchronous, also when asserted mid-operation): state=BOOT, pc_q=RESET_PC, flush_cnt=0, misalign_err=0, counters=0.
- Output values during reset: pc_next=RESET_PC, if_flush=1, fetch_valid=0, state_out=0.
- BOOT: lasts exactly one cycle after reset deasserts. pc_next=RESET_PC, if_flush=1, fetch_valid=0. Always goes to RUN; all inputs ignored.
- RUN/STALL next-PC priority, highest first:
  1. br_taken_i with aligned target: pc_next=br_target_i; flush_cnt<=FLUSH_CYCLES; state->RUN. Overrides stall_i and halt_i in the same cycle; the halt is dropped because it is on the wrong path.
  2. br_taken_i with misaligned target: pc_next=pc_q; misalign_err<=1; state->HALT.
  3. halt_i: pc_next=pc_q; state->HALT.
  4. stall_i: pc_next=pc_q; state->STALL.
  5. Otherwise: pc_next=pc_q+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); state->RUN.
- HALT: pc_next=pc_q; br_taken_i, stall_i and halt_i are ignored. resume_i moves to RUN with pc_next=pc_q+4 and clears misalign_err.
- flush_cnt (3 bits): reloads on every accepted redirect, including one during an active flush. Otherwise decrements by 1 per cycle, saturating at 0, regardless of stall.
- if_flush = (state==BOOT) | (flush_cnt!=0).
- fetch_valid = (state==RUN) & ~stall_i & (flush_cnt==0), evaluated from current-cycle registers and inputs.
- state_out mirrors the state register.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- Defined: perf_stall_cnt increments every cycle the state is STALL. perf_redir_cnt increments on every accepted (aligned) redirect. Both are 32-bit, saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports are tied to 32'h0 and no counter flops are synthesized. The port list is unchanged.

Test Plan:
- Reset release, no stimulus -> BOOT cycle with pc_next=0x0; then pc_next = 0x4, 0x8, 0xC on successive cycles; if_flush=1 only in BOOT; fetch_valid=1 from the first RUN cycle.
- At pc_q=0x10, br_taken_i=1 with target 0x40 for one cycle -> pc_next=0x40, then 0x44; if_flush high for exactly 2 cycles; fetch_valid=0 for those cycles; perf_redir_cnt=1 with the macro defined.
- stall_i high for 3 cycles at pc_q=0x20, with br_taken_i=1 (target 0x80) on the 2nd stall cycle -> PC holds 0x20, then redirects to 0x80 despite stall; state_out goes 2,1.
- halt_i at pc_q=0x30, then resume_i 5 cycles later -> pc_next held at 0x30 while state_out=3; after resume pc_next=0x34.
- br_taken_i with target 0x42 -> misalign_err=1, state HALT, PC holds; resume_i clears misalign_err.
- Force pc_q=0xFFFF_FFFC via redirect -> next pc_next=0x0000_0000. Assert reset mid-flush -> all outputs return to reset values immediately, without waiting for a clock edge.
